// File: rtl/sync_ram_pkg.sv
// ============================================================================
// sync_ram_pkg : shared clear-sequencer state encoding.     Rev 1.0
// ============================================================================
`default_nettype none

package sync_ram_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

endpackage : sync_ram_pkg

`default_nettype wire

// File: rtl/sync_ram_clear_ctrl.sv
// ============================================================================
// sync_ram_clear_ctrl : CLEAR/IDLE sequencer and clear address counter. Rev 1.0
// ============================================================================
`default_nettype none

module sync_ram_clear_ctrl
   import sync_ram_pkg::*;
#(
   parameter int ADDR_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear_start,
   output state_t               state,
   output logic [ADDR_BITS-1:0] clear_addr,
   output logic                 busy
);

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};

   state_t next_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= CLEAR;
         clear_addr <= '0;
      end else begin
         state <= next_state;
         // Wraps to zero after the last word, so IDLE always holds address 0.
         if (state == CLEAR) begin
            clear_addr <= clear_addr + 1'b1;
         end else begin
            clear_addr <= '0;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         CLEAR:   if (clear_addr == LAST_ADDR) next_state = IDLE;
         IDLE:    if (clear_start)             next_state = CLEAR;
         default: next_state = CLEAR;
      endcase
   end

   always_comb begin
      busy = (state == CLEAR);
   end

endmodule : sync_ram_clear_ctrl

`default_nettype wire

// File: rtl/sync_ram.sv
// ============================================================================
// sync_ram : single-port RAM with self-clearing sequencer, 1-cycle read.
// Optional per-bit write mask via SYNC_RAM_WRITE_MASK_EN.    Rev 1.0
// ============================================================================
`default_nettype none

module sync_ram
   import sync_ram_pkg::*;
#(
   parameter int                  ADDR_BITS   = 16,
   parameter int                  DATA_BITS   = 8,
   parameter logic [DATA_BITS-1:0] CLEAR_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_BITS-1:0] req_address,
   input  logic [DATA_BITS-1:0] req_data,
`ifdef SYNC_RAM_WRITE_MASK_EN
   input  logic [DATA_BITS-1:0] req_mask,
`endif
   output logic                 rsp_valid,
   output logic [DATA_BITS-1:0] rsp_data,
   input  logic                 clear_start,
   output logic                 busy
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [DATA_BITS-1:0] mem [0:DEPTH-1];

   state_t               state;
   logic [ADDR_BITS-1:0] clear_addr;
   logic                 accept;
   logic                 wr_accept;
   logic                 rd_accept;
   logic [DATA_BITS-1:0] wr_mask;
   logic [DATA_BITS-1:0] wr_word;

   sync_ram_clear_ctrl #(
      .ADDR_BITS (ADDR_BITS)
   ) u_clear_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_start (clear_start),
      .state       (state),
      .clear_addr  (clear_addr),
      .busy        (busy)
   );

   assign req_ready = (state == IDLE) && !clear_start;
   assign accept    = req_valid && req_ready;
   assign wr_accept = accept && req_write;
   assign rd_accept = accept && !req_write;

`ifdef SYNC_RAM_WRITE_MASK_EN
   assign wr_mask = req_mask;
`else
   assign wr_mask = '1;
`endif

   assign wr_word = (mem[req_address] & ~wr_mask) | (req_data & wr_mask);

   // Array is deliberately left out of reset; only the clear sequence fills it.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clear_addr] <= CLEAR_VALUE;
      end else if (wr_accept) begin
         mem[req_address] <= wr_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= rd_accept;
         if (rd_accept) begin
            rsp_data <= mem[req_address];
         end
      end
   end

endmodule : sync_ram

`default_nettype wire

// File: tb/tb_sync_ram.sv
// ============================================================================
// tb_sync_ram : directed table, corner sequences and random traffic vs model.
// ============================================================================
`default_nettype none

module tb_sync_ram;

   localparam int             AW = 4;
   localparam int             DW = 8;
   localparam int             NW = 16;
   localparam logic [DW-1:0]  CV = 8'hA5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_address;
   logic [DW-1:0] req_data;
   logic [DW-1:0] req_mask;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          clear_start;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   // Reference model: word array plus count of clear cycles still to run.
   logic [DW-1:0] m_mem [NW];
   int            m_clear_rem;
   logic          m_rv;
   logic [DW-1:0] m_rd;

   always #5 clk = ~clk;

   sync_ram #(
      .ADDR_BITS   (AW),
      .DATA_BITS   (DW),
      .CLEAR_VALUE (CV)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_address (req_address),
      .req_data    (req_data),
`ifdef SYNC_RAM_WRITE_MASK_EN
      .req_mask    (req_mask),
`endif
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .clear_start (clear_start),
      .busy        (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs, check ready, step model across the edge, check outputs.
   task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] m, input logic clr);
      logic [DW-1:0] eff;
      req_valid   = v;
      req_write   = w;
      req_address = a;
      req_data    = d;
      req_mask    = m;
      clear_start = clr;
`ifdef SYNC_RAM_WRITE_MASK_EN
      eff = m;
`else
      eff = '1;
`endif
      #1;
      chk("req_ready", {31'd0, req_ready}, {31'd0, (m_clear_rem == 0) && !clr});
      @(posedge clk);
      #1;
      m_rv = 1'b0;
      if (m_clear_rem > 0) begin
         m_mem[NW - m_clear_rem] = CV;
         m_clear_rem--;
      end else if (clr) begin
         m_clear_rem = NW;
      end else if (v) begin
         if (w) m_mem[a] = (m_mem[a] & ~eff) | (d & eff);
         else begin
            m_rv = 1'b1;
            m_rd = m_mem[a];
         end
      end
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
      chk("rsp_data",  {24'd0, rsp_data},  {24'd0, m_rd});
      chk("busy",      {31'd0, busy},      {31'd0, m_clear_rem > 0});
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, '1, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      m_clear_rem = NW;
      m_rv        = 1'b0;
      m_rd        = '0;
      chk("rst_busy",      {31'd0, busy},      32'd1);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data",  {24'd0, rsp_data},  32'd0);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic count_busy(input string name, input int clr_cycles);
      int n;
      n = 0;
      while (busy && n < 100) begin
         drive(1'b0, 1'b0, '0, '0, '1, n < clr_cycles);
         n++;
      end
      chk(name, n, 32'd16);
   endtask

   typedef struct {
      logic          v;
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          exp_rv;
      logic [DW-1:0] exp_rd;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{1'b1, 1'b1, 4'd3, 8'h3C, 1'b0, 8'hA5};
      tbl[1] = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 8'h3C};
      tbl[2] = '{1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 8'hA5};
      tbl[3] = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 8'hA5};
      tbl[4] = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 8'hA5};
      tbl[5] = '{1'b0, 1'b0, 4'd2, 8'h00, 1'b0, 8'hA5};
      tbl[6] = '{1'b1, 1'b1, 4'd1, 8'h5A, 1'b0, 8'hA5};
      tbl[7] = '{1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 8'h5A};
      tbl[8] = '{1'b0, 1'b0, 4'd1, 8'h00, 1'b0, 8'h5A};

      for (int i = 0; i < NW; i++) m_mem[i] = '0;
      m_clear_rem = NW;
      m_rv        = 1'b0;
      m_rd        = '0;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_address = '0;
      req_data    = '0;
      req_mask    = '1;
      clear_start = 1'b0;
      rst_n       = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      do_reset();

      // Clear after reset release, then reads of both end words.
      count_busy("reset_busy_len", 0);
      drive(1'b1, 1'b0, 4'd0, '0, '1, 1'b0);
      chk("read0_after_clear", {24'd0, rsp_data}, {24'd0, CV});
      drive(1'b1, 1'b0, 4'd15, '0, '1, 1'b0);
      chk("read15_after_clear", {24'd0, rsp_data}, {24'd0, CV});

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, '1, 1'b0);
         chk($sformatf("tbl%0d_rsp_valid", i), {31'd0, rsp_valid}, {31'd0, tbl[i].exp_rv});
         chk($sformatf("tbl%0d_rsp_data", i),  {24'd0, rsp_data},  {24'd0, tbl[i].exp_rd});
      end

      // clear_start beats a same-cycle write; re-asserting it mid-clear does nothing.
      drive(1'b1, 1'b1, 4'd5, 8'h77, '1, 1'b0);
      drive(1'b1, 1'b1, 4'd5, 8'h11, '1, 1'b1);
      count_busy("clear_busy_len", 3);
      drive(1'b1, 1'b0, 4'd5, '0, '1, 1'b0);
      chk("read5_after_clear", {24'd0, rsp_data}, {24'd0, CV});

      // Reset at clear cycle 8 restarts the full sequence.
      drive(1'b0, 1'b0, '0, '0, '1, 1'b1);
      repeat (8) idle();
      do_reset();
      count_busy("reset_mid_clear_busy_len", 0);

`ifdef SYNC_RAM_WRITE_MASK_EN
      drive(1'b1, 1'b1, 4'd7, 8'hFF, 8'h0F, 1'b0);
      drive(1'b1, 1'b0, 4'd7, '0, '1, 1'b0);
      chk("masked_write", {24'd0, rsp_data}, 32'hAF);
`endif

      for (int i = 0; i < 400; i++) begin
         logic          v;
         logic          w;
         logic          clr;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         logic [DW-1:0] m;
         v   = ($urandom_range(0, 3) != 0);
         w   = $urandom_range(0, 1) != 0;
         a   = AW'($urandom_range(0, NW - 1));
         d   = DW'($urandom);
         m   = DW'($urandom);
         clr = ($urandom_range(0, 49) == 0);
         drive(v, w, a, d, m, clr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sync_ram

`default_nettype wire

// File: doc/sync_ram.md
SYNC_RAM -- requirements
Module: sync_ram

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, address width; depth = 2**ADDR_BITS words.
REQ-002 SHALL have parameter DATA_BITS, default 8, word width.
REQ-003 SHALL have parameter CLEAR_VALUE, default all-zeros (DATA_BITS wide), value written to every word by the clear sequence.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_address  in  ADDR_BITS  word address.
REQ-010 req_data  in  DATA_BITS  write data.
REQ-011 rsp_valid  out  1  read data valid, one-cycle pulse per accepted read.
REQ-012 rsp_data  out  DATA_BITS  read data.
REQ-013 clear_start  in  1  request full-memory clear.
REQ-014 busy  out  1  clear sequence in progress.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR, IDLE.
REQ-016 CLEAR: write CLEAR_VALUE to word clear_addr each cycle; clear_addr starts at 0 and increments by 1.
REQ-017 CLEAR SHALL include the last word (2**ADDR_BITS-1); after writing it, go to IDLE next cycle; clear takes exactly 2**ADDR_BITS cycles.
REQ-018 busy SHALL be high exactly while in CLEAR.
REQ-019 req_ready SHALL be combinational: high iff state is IDLE and clear_start is low.
REQ-020 In IDLE with clear_start high, go to CLEAR next cycle with clear_addr = 0; any same-cycle request is not accepted.
REQ-021 Accepted write: memory[req_address] <= req_data at that edge; no response generated.
REQ-022 Accepted read: rsp_valid high on the following cycle with rsp_data = memory[req_address]; latency exactly 1.
REQ-023 Back-to-back accepted reads SHALL yield back-to-back rsp_valid pulses, one per cycle, in order.
REQ-024 Read one cycle after a write to the same address SHALL return the newly written data.
REQ-025 rsp_data SHALL hold its last value while rsp_valid is low.
REQ-026 Requests with req_valid high while req_ready is low SHALL have no effect; the requester holds them.
REQ-027 clear_start asserted during CLEAR SHALL be ignored; the sequence does not restart.

Reset
REQ-028 rst_n low SHALL immediately force state CLEAR, clear_addr 0, rsp_valid 0, rsp_data 0, busy 1, req_ready 0.
REQ-029 After rst_n deasserts, a full clear SHALL run before the first request is accepted.
REQ-030 Reset during CLEAR SHALL restart the clear from address 0; a read in flight SHALL produce no response.
REQ-031 Memory array contents SHALL NOT be reset directly; only the clear sequence initialises them.

Configuration
REQ-032 Macro SYNC_RAM_WRITE_MASK_EN, when defined, SHALL add port req_mask  in  DATA_BITS  per-bit write mask; an accepted write updates only bits whose mask bit is 1.
REQ-033 Without SYNC_RAM_WRITE_MASK_EN, there SHALL be no req_mask port and writes update the full word.
REQ-034 Clear writes SHALL ignore the mask in both configurations.

Structure
REQ-035 Package sync_ram_pkg SHALL hold the FSM state enum (CLEAR, IDLE).
REQ-036 Sub-module sync_ram_clear_ctrl SHALL contain the FSM and clear_addr counter; sync_ram holds the array, the read path and req_ready.

Verification (ADDR_BITS=4, DATA_BITS=8, CLEAR_VALUE=8'hA5)
REQ-037 Reset release -> busy high for exactly 16 cycles, req_ready low throughout; reads of addresses 0 and 15 then return 8'hA5.
REQ-038 Write 8'h3C @3, read @3 next cycle -> rsp_valid pulse one cycle after read acceptance, rsp_data 8'h3C.
REQ-039 Reads @0,@1,@2 on consecutive cycles -> three consecutive rsp_valid pulses in order; rsp_data holds after the last pulse.
REQ-040 clear_start with a same-cycle write @5 -> write not accepted, 16-cycle clear runs, @5 reads 8'hA5.
REQ-041 rst_n pulsed low at clear cycle 8 -> clear restarts at address 0 and busy lasts 16 cycles from release.
REQ-042 With SYNC_RAM_WRITE_MASK_EN: write 8'hFF with mask 8'h0F over 8'hA5 -> read returns 8'hAF.
